dsram_req_ctrl: RTL and testbench

DSRAM_REQ_CTRL -- requirements
Module: dsram_req_ctrl

---
 rtl/dsram_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_dsram_req_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dsram_req_ctrl.sv
// Data-side sram-like request controller: one outstanding load/store between
// the EX/MEM pipeline stages and the data bus, with flush cancellation.
module dsram_req_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_req_valid,
  input  logic        es_req_wr,
  input  logic [1:0]  es_req_size,
  input  logic [31:0] es_req_addr,
  input  logic [3:0]  es_req_wstrb,
  input  logic [31:0] es_req_wdata,
  output logic        es_req_accept,
  output logic        ms_data_ok,
  output logic [31:0] ms_rdata,
  input  logic        ms_resp_ack,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        busy
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic              cancel_q, cancel_d;
  req_t              req_q, req_d;
  logic              latch_en;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign req_d = '{wr: es_req_wr, size: es_req_size, addr: es_req_addr,
                   wstrb: es_req_wstrb, wdata: es_req_wdata};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, cancel tracking, request latch and response capture control
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    latch_en = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (es_req_valid && !flush) begin
          latch_en = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) cancel_d = 1'b1;
        if (data_sram_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (data_sram_data_ok) begin
          if (cancel_q || flush) begin
            cancel_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rdata_d = req_q.wr ? DATA_W'(0) : data_sram_rdata;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (ms_resp_ack || flush) begin
          if (es_req_valid && !flush) begin
            latch_en = 1'b1;
            state_d  = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: cancel flag, latched request, held response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_q <= 1'b0;
      req_q    <= '0;
      rdata_q  <= '0;
    end else begin
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      if (latch_en) req_q <= req_d;
    end
  end

  // Output decode; accept is suppressed once the access has been cancelled
  always_comb begin
    busy          = 1'b0;
    data_sram_req = 1'b0;
    es_req_accept = 1'b0;
    ms_data_ok    = 1'b0;
    case (state_q)
      S_REQ: begin
        busy          = 1'b1;
        data_sram_req = 1'b1;
        es_req_accept = data_sram_addr_ok && !(cancel_q || flush);
      end
      S_WAIT:  busy = 1'b1;
      S_RESP: begin
        busy       = 1'b1;
        ms_data_ok = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign ms_rdata        = rdata_q;
  assign data_sram_wr    = req_q.wr;
  assign data_sram_size  = req_q.size;
  assign data_sram_addr  = req_q.addr;
  assign data_sram_wstrb = req_q.wstrb;
  assign data_sram_wdata = req_q.wdata;

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Directed bench for dsram_req_ctrl: load/store, flush in REQ/WAIT,
// back-to-back issue and reset during an outstanding access.
module tb_dsram_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_req_valid, es_req_wr;
  logic [1:0]  es_req_size;
  logic [31:0] es_req_addr, es_req_wdata;
  logic [3:0]  es_req_wstrb;
  logic        es_req_accept, ms_data_ok;
  logic [31:0] ms_rdata;
  logic        ms_resp_ack, flush;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int dok_cnt = 0;

  dsram_req_ctrl dut (
    .clk(clk), .resetn(resetn),
    .es_req_valid(es_req_valid), .es_req_wr(es_req_wr), .es_req_size(es_req_size),
    .es_req_addr(es_req_addr), .es_req_wstrb(es_req_wstrb), .es_req_wdata(es_req_wdata),
    .es_req_accept(es_req_accept), .ms_data_ok(ms_data_ok), .ms_rdata(ms_rdata),
    .ms_resp_ack(ms_resp_ack), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse/cycle counters sampled mid-cycle, after inputs have settled
  always @(negedge clk) begin
    if (es_req_accept) acc_cnt++;
    if (ms_data_ok) dok_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata);
    es_req_valid = 1'b1; es_req_wr = wr; es_req_size = 2'd2;
    es_req_addr = addr; es_req_wstrb = strb; es_req_wdata = wdata;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", data_sram_req); end
    n_cmp++; if (es_req_accept !== 1'b0) begin n_fail++; $display("FAIL reset_accept: got %b want 0", es_req_accept); end
    n_cmp++; if (ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b want 0", ms_data_ok); end
    n_cmp++; if (ms_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", ms_rdata); end
    n_cmp++; if (data_sram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", data_sram_addr); end
    tick(); resetn = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int a0;
    a0 = acc_cnt;
    issue(1'b0, 32'h0000_1000, 4'h0, 32'h0);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_idle_busy: got %b want 0", busy); end
    tick(); es_req_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_0000; #1;
    n_cmp++; if (data_sram_req !== 1'b1) begin n_fail++; $display("FAIL load_req: got %b want 1", data_sram_req); end
    n_cmp++; if (data_sram_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL load_addr: got %h want 00001000", data_sram_addr); end
    n_cmp++; if (data_sram_size !== 2'd2 || data_sram_wr !== 1'b0) begin n_fail++; $display("FAIL load_size_wr: got %0d/%b want 2/0", data_sram_size, data_sram_wr); end
    n_cmp++; if (es_req_accept !== 1'b0) begin n_fail++; $display("FAIL load_accept_early: got %b want 0", es_req_accept); end
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (data_sram_req !== 1'b1 || es_req_accept !== 1'b0) begin n_fail++; $display("FAIL load_req_hold: got req=%b acc=%b want 1/0", data_sram_req, es_req_accept); end
    tick(); data_sram_addr_ok = 1'b1; #1;
    n_cmp++; if (es_req_accept !== 1'b1) begin n_fail++; $display("FAIL load_accept: got %b want 1", es_req_accept); end
    tick(); data_sram_addr_ok = 1'b0; #1;
    n_cmp++; if (data_sram_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_wait: got req=%b busy=%b want 0/1", data_sram_req, busy); end
    tick();
    tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
    n_cmp++; if (ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL load_data_ok_early: got %b want 0", ms_data_ok); end
    tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1) begin n_fail++; $display("FAIL load_data_ok: got %b want 1", ms_data_ok); end
    n_cmp++; if (ms_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL load_rdata: got %h want 12345678", ms_rdata); end
    tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_CAFE;
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1 || ms_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL load_hold: got ok=%b rdata=%h want 1/12345678", ms_data_ok, ms_rdata); end
    n_cmp++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL load_accept_count: got %0d want 1", acc_cnt - a0); end
    ms_resp_ack = 1'b1;
    tick(); ms_resp_ack = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL load_release: got ok=%b busy=%b want 0/0", ms_data_ok, busy); end
  endtask

  task automatic test_store();
    issue(1'b1, 32'h0000_2004, 4'b1100, 32'hAABB_CCDD);
    tick(); es_req_valid = 1'b0; data_sram_addr_ok = 1'b1; #1;
    n_cmp++; if (data_sram_wr !== 1'b1 || data_sram_size !== 2'd2) begin n_fail++; $display("FAIL store_wr_size: got %b/%0d want 1/2", data_sram_wr, data_sram_size); end
    n_cmp++; if (data_sram_addr !== 32'h0000_2004) begin n_fail++; $display("FAIL store_addr: got %h want 00002004", data_sram_addr); end
    n_cmp++; if (data_sram_wstrb !== 4'b1100) begin n_fail++; $display("FAIL store_wstrb: got %b want 1100", data_sram_wstrb); end
    n_cmp++; if (data_sram_wdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL store_wdata: got %h want aabbccdd", data_sram_wdata); end
    n_cmp++; if (es_req_accept !== 1'b1) begin n_fail++; $display("FAIL store_accept: got %b want 1", es_req_accept); end
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1) begin n_fail++; $display("FAIL store_data_ok: got %b want 1", ms_data_ok); end
    n_cmp++; if (ms_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", ms_rdata); end
    ms_resp_ack = 1'b1;
    tick(); ms_resp_ack = 1'b0;
  endtask

  task automatic test_flush_wait();
    int d0;
    d0 = dok_cnt;
    issue(1'b0, 32'h0000_3000, 4'h0, 32'h0);
    tick(); es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fwait_still_wait: got busy=%b want 1", busy); end
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL fwait_idle: got busy=%b ok=%b want 0/0", busy, ms_data_ok); end
    n_cmp++; if (dok_cnt - d0 !== 0) begin n_fail++; $display("FAIL fwait_no_resp: got %0d want 0", dok_cnt - d0); end
    issue(1'b0, 32'h0000_3004, 4'h0, 32'h0);
    tick(); es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D; #1;
    n_cmp++; if (ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL fwait_latency_early: got %b want 0", ms_data_ok); end
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1 || ms_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL fwait_next_load: got ok=%b rdata=%h want 1/0badf00d", ms_data_ok, ms_rdata); end
    ms_resp_ack = 1'b1;
    tick(); ms_resp_ack = 1'b0;
  endtask

  task automatic test_flush_req();
    int a0, d0;
    a0 = acc_cnt; d0 = dok_cnt;
    issue(1'b0, 32'h0000_5000, 4'h0, 32'h0);
    tick(); es_req_valid = 1'b0; flush = 1'b1; #1;
    n_cmp++; if (data_sram_req !== 1'b1 || es_req_accept !== 1'b0) begin n_fail++; $display("FAIL freq_c0: got req=%b acc=%b want 1/0", data_sram_req, es_req_accept); end
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      n_cmp++; if (data_sram_req !== 1'b1 || es_req_accept !== 1'b0) begin n_fail++; $display("FAIL freq_c%0d: got req=%b acc=%b want 1/0", i, data_sram_req, es_req_accept); end
    end
    tick(); flush = 1'b0; data_sram_addr_ok = 1'b1; #1;
    n_cmp++; if (data_sram_req !== 1'b1 || es_req_accept !== 1'b0) begin n_fail++; $display("FAIL freq_addr_ok: got req=%b acc=%b want 1/0", data_sram_req, es_req_accept); end
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL freq_idle: got busy=%b ok=%b want 0/0", busy, ms_data_ok); end
    n_cmp++; if (acc_cnt - a0 !== 0 || dok_cnt - d0 !== 0) begin n_fail++; $display("FAIL freq_counts: got acc=%0d ok=%0d want 0/0", acc_cnt - a0, dok_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h0000_4000, 4'h0, 32'h0);
    tick(); es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1 || ms_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_first: got ok=%b rdata=%h want 1/11112222", ms_data_ok, ms_rdata); end
    ms_resp_ack = 1'b1;
    issue(1'b0, 32'h0000_4100, 4'h0, 32'h0);
    tick(); ms_resp_ack = 1'b0; es_req_valid = 1'b0; #1;
    n_cmp++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h0000_4100) begin n_fail++; $display("FAIL b2b_req: got req=%b addr=%h want 1/00004100", data_sram_req, data_sram_addr); end
    n_cmp++; if (ms_data_ok !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_state: got ok=%b busy=%b want 0/1", ms_data_ok, busy); end
    data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_4444;
    tick(); data_sram_data_ok = 1'b0; #1;
    n_cmp++; if (ms_data_ok !== 1'b1 || ms_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_second: got ok=%b rdata=%h want 1/33334444", ms_data_ok, ms_rdata); end
    ms_resp_ack = 1'b1;
    tick(); ms_resp_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int d0;
    issue(1'b0, 32'h0000_6000, 4'h0, 32'h0);
    tick(); es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait: got busy=%b want 1", busy); end
    resetn = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || data_sram_req !== 1'b0 || ms_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got busy=%b req=%b ok=%b want 0/0/0", busy, data_sram_req, ms_data_ok); end
    n_cmp++; if (ms_rdata !== 32'h0 || data_sram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_data: got rdata=%h addr=%h want 0/0", ms_rdata, data_sram_addr); end
    tick(); resetn = 1'b1;
    d0 = dok_cnt;
    tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9999_9999;
    tick(); data_sram_data_ok = 1'b0; #1;
    tick();
    n_cmp++; if (ms_data_ok !== 1'b0 || busy !== 1'b0 || dok_cnt - d0 !== 0) begin n_fail++; $display("FAIL rst_stray: got ok=%b busy=%b cnt=%0d want 0/0/0", ms_data_ok, busy, dok_cnt - d0); end
  endtask

  initial begin
    resetn = 1'b0;
    es_req_valid = 1'b0; es_req_wr = 1'b0; es_req_size = 2'd0;
    es_req_addr = 32'h0; es_req_wstrb = 4'h0; es_req_wdata = 32'h0;
    ms_resp_ack = 1'b0; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_flush_wait();
    test_flush_req();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
